// File: rtl/block_playout_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | block_playout_scheduler: two-slot ping-pong block buffer, one byte per tick |
// | Optional macro PLAYOUT_STATS_EN adds underrun/drop counters.  Rev 1.0       |
// +----------------------------------------------------------------------------+
module block_playout_scheduler #(
  parameter int NUM_BYTES = 16,
  parameter int BYTE_W    = 8
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        flush_in,
  input  logic                        block_valid_in,
  input  logic [NUM_BYTES*BYTE_W-1:0] block_in,
  input  logic                        tick_in,
  output logic                        block_ready_out,
  output logic [BYTE_W-1:0]           sample_out,
  output logic                        sample_valid_out,
  output logic                        busy_out,
  output logic [1:0]                  fill_out,
  output logic [7:0]                  underrun_cnt_out,
  output logic [7:0]                  drop_cnt_out
);

  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int BLK_W = NUM_BYTES * BYTE_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         full_q, full_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               primed_q, primed_d;
  logic [BYTE_W-1:0]  sample_q, sample_d;
  logic               sample_valid_q, sample_valid_d;
  logic [BLK_W-1:0]   slot_q [2];
  logic [BLK_W-1:0]   slot_d [2];
  logic               ready;
  logic [BLK_W-1:0]   rd_block;
  logic [BYTE_W-1:0]  cur_byte;

  // Ready depends only on registered full flags, never on inputs.
  assign ready            = ~(full_q[0] & full_q[1]);
  assign block_ready_out  = ready;
  assign fill_out         = {1'b0, full_q[0]} + {1'b0, full_q[1]};
  assign busy_out         = (state_q == PLAY);
  assign sample_out       = sample_q;
  assign sample_valid_out = sample_valid_q;
  assign rd_block         = slot_q[rd_ptr_q];

  always_comb begin
    cur_byte = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (idx_q == IDX_W'(i)) cur_byte = rd_block[i*BYTE_W +: BYTE_W];
    end
  end

  always_comb begin
    state_d        = state_q;
    full_d         = full_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    idx_d          = idx_q;
    primed_d       = primed_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    slot_d         = slot_q;

    if (flush_in) begin
      state_d  = IDLE;
      full_d   = 2'b00;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      idx_d    = '0;
      primed_d = 1'b0;
      sample_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tick_in && primed_q) begin
            sample_d       = '0;
            sample_valid_d = 1'b1;
          end
          if (full_q[rd_ptr_q]) begin
            state_d  = PLAY;
            primed_d = 1'b1;
          end
        end
        PLAY: begin
          if (tick_in) begin
            sample_d       = cur_byte;
            sample_valid_d = 1'b1;
            if (idx_q == LAST_IDX) begin
              full_d[rd_ptr_q] = 1'b0;
              idx_d            = '0;
              rd_ptr_d         = ~rd_ptr_q;
              state_d          = full_q[~rd_ptr_q] ? PLAY : IDLE;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase

      // Write slot is always the empty one, so it never collides with a freed slot.
      if (block_valid_in && ready) begin
        slot_d[wr_ptr_q] = block_in;
        full_d[wr_ptr_q] = 1'b1;
        wr_ptr_d         = ~wr_ptr_q;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q        <= IDLE;
      full_q         <= 2'b00;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      idx_q          <= '0;
      primed_q       <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      full_q         <= full_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      idx_q          <= idx_d;
      primed_q       <= primed_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  // Slot payload needs no reset: the full flags qualify it.
  always_ff @(posedge clk_in) begin
    slot_q <= slot_d;
  end

`ifdef PLAYOUT_STATS_EN
  logic [7:0] underrun_cnt_q, underrun_cnt_d;
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    underrun_cnt_d = underrun_cnt_q;
    drop_cnt_d     = drop_cnt_q;
    if (!flush_in) begin
      if (tick_in && (state_q == IDLE) && primed_q && (underrun_cnt_q != 8'hFF))
        underrun_cnt_d = underrun_cnt_q + 8'd1;
      if (block_valid_in && !ready && (drop_cnt_q != 8'hFF))
        drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      underrun_cnt_q <= 8'd0;
      drop_cnt_q     <= 8'd0;
    end else begin
      underrun_cnt_q <= underrun_cnt_d;
      drop_cnt_q     <= drop_cnt_d;
    end
  end

  assign underrun_cnt_out = underrun_cnt_q;
  assign drop_cnt_out     = drop_cnt_q;
`else
  assign underrun_cnt_out = 8'd0;
  assign drop_cnt_out     = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_block_playout_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_block_playout_scheduler: vectors, directed sequences and a queue model  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_block_playout_scheduler;

  localparam int NB = 16;
  localparam int BW = 8;
`ifdef PLAYOUT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef logic [NB*BW-1:0] blk_t;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          bv    = 1'b0;
  logic          tick  = 1'b0;
  blk_t          blk   = '0;
  logic          ready, sv, busy;
  logic [BW-1:0] sample;
  logic [1:0]    fill;
  logic [7:0]    ucnt, dcnt;

  int checks = 0;
  int errors = 0;

  blk_t blk_a, blk_b, blk_c;

  always #5 clk = ~clk;

  block_playout_scheduler #(.NUM_BYTES(NB), .BYTE_W(BW)) dut (
    .clk_in           (clk),
    .rst_in           (rst_n),
    .flush_in         (flush),
    .block_valid_in   (bv),
    .block_in         (blk),
    .tick_in          (tick),
    .block_ready_out  (ready),
    .sample_out       (sample),
    .sample_valid_out (sv),
    .busy_out         (busy),
    .fill_out         (fill),
    .underrun_cnt_out (ucnt),
    .drop_cnt_out     (dcnt)
  );

  // Reference model: a FIFO of whole blocks plus a play position.
  blk_t          m_q[$];
  int            m_pos;
  bit            m_play, m_primed, m_sv;
  logic [BW-1:0] m_sample;
  int            m_under, m_drop;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pos = 0; m_play = 0; m_primed = 0; m_sv = 0; m_sample = '0;
    m_under = 0; m_drop = 0;
  endtask

  task automatic model_step();
    int   fill_pre;
    bit   pop;
    blk_t h;
    fill_pre = m_q.size();
    pop = 0;
    if (flush) begin
      m_q.delete();
      m_pos = 0; m_play = 0; m_primed = 0; m_sv = 0; m_sample = '0;
    end else begin
      m_sv = 0;
      if (m_play && tick) begin
        h = m_q[0];
        m_sample = h[m_pos*BW +: BW];
        m_sv = 1;
        m_pos++;
        if (m_pos == NB) begin
          pop = 1; m_pos = 0; m_play = (fill_pre == 2);
        end
      end else if (!m_play) begin
        if (tick && m_primed) begin
          m_sample = '0; m_sv = 1;
          if (m_under < 255) m_under++;
        end
        if (fill_pre > 0) begin
          m_play = 1; m_primed = 1;
        end
      end
      if (pop) void'(m_q.pop_front());
      if (bv) begin
        if (fill_pre < 2) m_q.push_back(blk);
        else if (m_drop < 255) m_drop++;
      end
    end
  endtask

  task automatic compare_model();
    check("model_ready",  32'(ready),  32'(m_q.size() < 2));
    check("model_fill",   32'(fill),   32'(m_q.size()));
    check("model_busy",   32'(busy),   32'(m_play));
    check("model_valid",  32'(sv),     32'(m_sv));
    check("model_sample", 32'(sample), 32'(m_sample));
    check("model_underrun", 32'(ucnt), STATS ? 32'(m_under) : 32'd0);
    check("model_drop",     32'(dcnt), STATS ? 32'(m_drop)  : 32'd0);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_step();
    compare_model();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; flush = 1'b0; bv = 1'b0; tick = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send(input blk_t b);
    bv = 1'b1; blk = b;
    cycle();
    bv = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cycle();
    tick = 1'b0;
  endtask

  function automatic blk_t sel_blk(input int sel);
    case (sel)
      1:       return blk_a;
      2:       return blk_b;
      3:       return blk_c;
      default: return '0;
    endcase
  endfunction

  typedef struct {
    bit flush; bit valid; bit tick; int sel;
    int fill; bit rdy; bit busy; bit sv; int smp; int drop;
  } vec_t;

  vec_t tbl [13];

  initial begin
    for (int i = 0; i < NB; i++) begin
      blk_a[i*BW +: BW] = BW'(i);
      blk_b[i*BW +: BW] = BW'(8'h80 + i);
      blk_c[i*BW +: BW] = BW'(8'h40 + i);
    end
    //           fl va ti sel  fill rdy busy sv smp  drop
    tbl[0]  = '{0, 1, 0, 1,   1,   1,  0,   0, 0,   0};
    tbl[1]  = '{0, 0, 0, 0,   1,   1,  1,   0, 0,   0};
    tbl[2]  = '{0, 1, 0, 2,   2,   0,  1,   0, 0,   0};
    tbl[3]  = '{0, 1, 0, 3,   2,   0,  1,   0, 0,   1};
    tbl[4]  = '{0, 0, 1, 0,   2,   0,  1,   1, 0,   1};
    tbl[5]  = '{0, 1, 1, 3,   2,   0,  1,   1, 1,   2};
    tbl[6]  = '{0, 0, 1, 0,   2,   0,  1,   1, 2,   2};
    tbl[7]  = '{0, 0, 1, 0,   2,   0,  1,   1, 3,   2};
    tbl[8]  = '{0, 0, 1, 0,   2,   0,  1,   1, 4,   2};
    tbl[9]  = '{1, 0, 1, 0,   0,   1,  0,   0, 0,   2};
    tbl[10] = '{0, 0, 1, 0,   0,   1,  0,   0, 0,   2};
    tbl[11] = '{0, 1, 0, 1,   1,   1,  0,   0, 0,   2};
    tbl[12] = '{0, 0, 0, 0,   1,   1,  1,   0, 0,   2};

    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready",  32'(ready),  32'd1);
    check("rst_fill",   32'(fill),   32'd0);
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_valid",  32'(sv),     32'd0);
    check("rst_sample", 32'(sample), 32'd0);
    check("rst_ucnt",   32'(ucnt),   32'd0);
    check("rst_dcnt",   32'(dcnt),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: drop on full, play to idx 5, flush with tick, unprimed tick.
    for (int i = 0; i < 13; i++) begin
      flush = tbl[i].flush; bv = tbl[i].valid; tick = tbl[i].tick;
      blk = sel_blk(tbl[i].sel);
      cycle();
      check($sformatf("vec%0d_fill", i),  32'(fill),   32'(tbl[i].fill));
      check($sformatf("vec%0d_ready", i), 32'(ready),  32'(tbl[i].rdy));
      check($sformatf("vec%0d_busy", i),  32'(busy),   32'(tbl[i].busy));
      check($sformatf("vec%0d_valid", i), 32'(sv),     32'(tbl[i].sv));
      check($sformatf("vec%0d_sample", i), 32'(sample), 32'(tbl[i].smp));
      check($sformatf("vec%0d_drop", i),  32'(dcnt),   STATS ? 32'(tbl[i].drop) : 32'd0);
    end
    flush = 1'b0; bv = 1'b0; tick = 1'b0;

    // Single block playout then three underruns.
    apply_reset();
    send(blk_a);
    check("one_fill", 32'(fill), 32'd1);
    cycle();
    check("one_busy", 32'(busy), 32'd1);
    for (int i = 0; i < NB; i++) begin
      do_tick();
      check($sformatf("one_valid%0d", i), 32'(sv), 32'd1);
      check($sformatf("one_sample%0d", i), 32'(sample), 32'(i));
      check($sformatf("one_busy%0d", i), 32'(busy), (i == NB-1) ? 32'd0 : 32'd1);
      check($sformatf("one_fill%0d", i), 32'(fill), (i == NB-1) ? 32'd0 : 32'd1);
      cycle();
      check($sformatf("one_gap%0d", i), 32'(sv), 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      do_tick();
      check($sformatf("urun_valid%0d", i), 32'(sv), 32'd1);
      check($sformatf("urun_sample%0d", i), 32'(sample), 32'd0);
      cycle();
    end
    check("urun_cnt", 32'(ucnt), STATS ? 32'd3 : 32'd0);

    // Two blocks back-to-back, ticks every cycle, seamless handover.
    apply_reset();
    send(blk_a);
    send(blk_b);
    check("two_fill2", 32'(fill), 32'd2);
    tick = 1'b1;
    for (int k = 0; k < 2*NB; k++) begin
      cycle();
      check($sformatf("two_valid%0d", k), 32'(sv), 32'd1);
      check($sformatf("two_sample%0d", k), 32'(sample),
            (k < NB) ? 32'(k) : 32'(8'h80 + k - NB));
      if (k == NB-1)   check("two_fill1", 32'(fill), 32'd1);
      if (k == 2*NB-1) check("two_fill0", 32'(fill), 32'd0);
    end
    tick = 1'b0;
    cycle();
    check("two_idle", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a block.
    send(blk_c);
    cycle();
    repeat (3) do_tick();
    check("arst_pre_valid", 32'(sv), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_valid",  32'(sv),     32'd0);
    check("arst_sample", 32'(sample), 32'd0);
    check("arst_busy",   32'(busy),   32'd0);
    check("arst_fill",   32'(fill),   32'd0);
    check("arst_ready",  32'(ready),  32'd1);
    check("arst_ucnt",   32'(ucnt),   32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    check("arst_after_ready", 32'(ready), 32'd1);
    check("arst_after_fill",  32'(fill),  32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      bv    = ($urandom_range(0, 99) < 12);
      tick  = ($urandom_range(0, 99) < 25);
      flush = ($urandom_range(0, 199) == 0);
      for (int w = 0; w < NB*BW/32; w++) blk[w*32 +: 32] = $urandom;
      cycle();
    end
    flush = 1'b0; bv = 1'b0; tick = 1'b0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
